// File: rtl/max7219_display_driver.sv
// Drives a MAX7219 over LOAD/DIN/CLK: config frames, then an endless hh:mm:ss digit refresh.
// Frame = 35*CLK_DIV cycles, no backpressure; `DISPLAY_DP_BLINK_EN lights colon DPs on even seconds.
module max7219_display_driver #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'hF
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  output logic       o_serial_load,
  output logic       o_serial_dout,
  output logic       o_serial_clk,
  output logic       o_init_done
);

  typedef enum logic [2:0] {IDLE, START, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [3:0]  frame_idx;
  logic [14:0] shreg;
  logic [4:0]  snap_h;
  logic [5:0]  snap_m, snap_s;
  logic [4:0]  src_h;
  logic [5:0]  src_m, src_s;
  logic [3:0]  digit_addr;
  logic [7:0]  seg_byte;
  logic [15:0] frame_word;
  logic        cnt_last;
  logic        first_of_sweep;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] r;
    r = v - 6'(bcd_tens(v)) * 6'd10;
    return 4'(r);
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h7E;
      4'd1:    return 8'h30;
      4'd2:    return 8'h6D;
      4'd3:    return 8'h79;
      4'd4:    return 8'h33;
      4'd5:    return 8'h5B;
      4'd6:    return 8'h5F;
      4'd7:    return 8'h70;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h7B;
      default: return 8'h00;
    endcase
  endfunction

  assign cnt_last       = (cnt == 16'(CLK_DIV - 1));
  assign first_of_sweep = (frame_idx == 4'd5);
  // The addr-1 frame is built from the live inputs in the same cycle they are snapshotted.
  assign src_h      = first_of_sweep ? i_hours   : snap_h;
  assign src_m      = first_of_sweep ? i_minutes : snap_m;
  assign src_s      = first_of_sweep ? i_seconds : snap_s;
  assign digit_addr = frame_idx - 4'd4;

  always_comb begin
    seg_byte = 8'h00;
    case (digit_addr)
      4'd1:    seg_byte = seg7(bcd_tens({1'b0, src_h}));
      4'd2:    seg_byte = seg7(bcd_ones({1'b0, src_h}));
      4'd3:    seg_byte = seg7(bcd_tens(src_m));
      4'd4:    seg_byte = seg7(bcd_ones(src_m));
      4'd5:    seg_byte = seg7(bcd_tens(src_s));
      4'd6:    seg_byte = seg7(bcd_ones(src_s));
      default: seg_byte = 8'h00;
    endcase
`ifdef DISPLAY_DP_BLINK_EN
    if (digit_addr == 4'd2 || digit_addr == 4'd4) seg_byte[7] = ~src_s[0];
`endif
    frame_word = 16'h0000;
    case (frame_idx)
      4'd0:    frame_word = 16'h0C01;
      4'd1:    frame_word = 16'h0900;
      4'd2:    frame_word = 16'h0B07;
      4'd3:    frame_word = {8'h0A, 4'h0, INTENSITY};
      4'd4:    frame_word = 16'h0F00;
      default: frame_word = {4'h0, digit_addr, seg_byte};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 4'd0;
      frame_idx     <= 4'd0;
      shreg         <= 15'd0;
      snap_h        <= 5'd0;
      snap_m        <= 6'd0;
      snap_s        <= 6'd0;
      o_serial_load <= 1'b1;
      o_serial_clk  <= 1'b0;
      o_serial_dout <= 1'b0;
      o_init_done   <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (state == IDLE || cnt_last) begin
            state         <= START;
            cnt           <= 16'd0;
            shreg         <= frame_word[14:0];
            o_serial_dout <= frame_word[15];
            o_serial_load <= 1'b0;
            if (first_of_sweep) begin
              snap_h <= i_hours;
              snap_m <= i_minutes;
              snap_s <= i_seconds;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        START: begin
          if (cnt_last) begin
            state   <= SHIFT_LO;
            cnt     <= 16'd0;
            bit_idx <= 4'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT_LO: begin
          if (cnt_last) begin
            state        <= SHIFT_HI;
            cnt          <= 16'd0;
            o_serial_clk <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT_HI: begin
          if (cnt_last) begin
            cnt          <= 16'd0;
            o_serial_clk <= 1'b0;
            if (bit_idx == 4'd15) begin
              state <= LATCH;
            end else begin
              state         <= SHIFT_LO;
              bit_idx       <= bit_idx + 4'd1;
              o_serial_dout <= shreg[14];
              shreg         <= {shreg[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LATCH: begin
          if (cnt_last) begin
            state         <= GAP;
            cnt           <= 16'd0;
            o_serial_load <= 1'b1;
            if (frame_idx == 4'd4) o_init_done <= 1'b1;
            frame_idx     <= (frame_idx == 4'd12) ? 4'd5 : frame_idx + 4'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_display_driver.sv
// Scoreboard bench: two driver instances (CLK_DIV 2 and 3) decoded at LOAD rising edges
// against a frame-schedule reference model; timing rules checked per sample.
module tb_max7219_display_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] hours = 5'd10;
  logic [5:0] minutes = 6'd59;
  logic [5:0] seconds = 6'd0;
  logic [1:0] load_w, dout_w, sclk_w, done_w;

  int total = 0;
  int bad = 0;
  int nchk [2] = '{0, 0};
  int pos = 0;

  logic [7:0] seg_tab [10] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                               8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};

  always #5 clk = ~clk;

  task automatic check(input int lane, input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL lane%0d %s: got 0x%0h required 0x%0h", lane, name, act, req);
    end
  endtask

  // Expected 16-bit word of frame k (counted from reset) given the sweep snapshot.
  function automatic logic [15:0] exp_frame(input int k, input logic [3:0] inten,
                                            input int h, input int m, input int s);
    int a;
    logic [7:0] d;
    case (k)
      0: return 16'h0C01;
      1: return 16'h0900;
      2: return 16'h0B07;
      3: return {8'h0A, 4'h0, inten};
      4: return 16'h0F00;
      default: ;
    endcase
    a = (k - 5) % 8 + 1;
    case (a)
      1: d = seg_tab[h / 10];
      2: d = seg_tab[h % 10];
      3: d = seg_tab[m / 10];
      4: d = seg_tab[m % 10];
      5: d = seg_tab[s / 10];
      6: d = seg_tab[s % 10];
      default: d = 8'h00;
    endcase
`ifdef DISPLAY_DP_BLINK_EN
    if (a == 2 || a == 4) d[7] = (s % 2 == 0);
`endif
    return {4'h0, 4'(a), d};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int         C   = (g == 0) ? 2 : 3;
    localparam logic [3:0] INT = (g == 0) ? 4'hF : 4'h5;

    max7219_display_driver #(.CLK_DIV(C), .INTENSITY(INT)) dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_hours       (hours),
      .i_minutes     (minutes),
      .i_seconds     (seconds),
      .o_serial_load (load_w[g]),
      .o_serial_dout (dout_w[g]),
      .o_serial_clk  (sclk_w[g]),
      .o_init_done   (done_w[g])
    );

    logic [15:0] q [$];
    int n = 0;
    int k, sh = 0, sm = 0, ss = 0;

    // Reference: frame k begins every 35*C cycles after reset release; push its word then.
    always @(posedge clk) begin
      if (!reset_n) begin
        n = 0;
        q.delete();
      end else begin
        if (n % (35 * C) == 0) begin
          k = n / (35 * C);
          if (k >= 5 && (k - 5) % 8 == 0) begin
            sh = int'(hours);
            sm = int'(minutes);
            ss = int'(seconds);
          end
          q.push_back(exp_frame(k, INT, sh, sm, ss));
        end
        n++;
      end
    end

    int low_cnt = 0, high_cnt = 0, nbits = 0, rises = 0;
    logic pl = 1'b1, ps = 1'b0, pd = 1'b0, chk_next = 1'b0, chk_val = 1'b0;
    logic l, s, d;
    logic [15:0] shw = 16'h0, e;

    always @(posedge clk) begin
      #1;
      l = load_w[g];
      s = sclk_w[g];
      d = dout_w[g];
      if (!reset_n) begin
        check(g, "reset_load", int'(l), 1);
        check(g, "reset_sclk", int'(s), 0);
        check(g, "reset_dout", int'(d), 0);
        check(g, "reset_init_done", int'(done_w[g]), 0);
        low_cnt = 0; high_cnt = 0; nbits = 0; rises = 0; chk_next = 1'b0;
      end else begin
        if (!ps && s) begin
          check(g, "dout_stable_before_rise", int'(d), int'(pd));
          shw = {shw[14:0], d};
          nbits++;
          chk_next = 1'b1;
          chk_val = d;
        end else if (chk_next) begin
          check(g, "dout_stable_after_rise", int'(d), int'(chk_val));
          chk_next = 1'b0;
        end
        if (!pl && l) begin
          check(g, "bits_per_frame", nbits, 16);
          check(g, "load_low_cycles", low_cnt, 34 * C);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL lane%0d frame: got 0x%0h required no frame", g, shw);
          end else begin
            e = q.pop_front();
            check(g, "frame", int'(shw), int'(e));
            nchk[g]++;
          end
          rises++;
          nbits = 0;
          low_cnt = 0;
          high_cnt = 1;
        end else if (l) begin
          high_cnt++;
        end else begin
          if (pl && rises > 0) check(g, "gap_cycles", high_cnt, C);
          low_cnt++;
        end
        check(g, "init_done", int'(done_w[g]), (rises >= 5) ? 1 : 0);
      end
      pl = l;
      ps = s;
      pd = d;
    end
  end

  task automatic step();
    @(negedge clk);
    pos++;
  endtask

  task automatic run_to(input int target);
    while (pos < target) step();
  endtask

  initial begin
    int kk;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    pos = 0;
    // 10:59:00 through config and two lane-0 sweeps.
    run_to(1470);
    hours = 5'd23; minutes = 6'd59; seconds = 6'd59;
    // Lane-0 frame 23 is addr3; change minutes while it shifts.
    run_to(70 * 23 + 20);
    minutes = 6'd0;
    run_to(2590);
    minutes = 6'd59; seconds = 6'd58;
    run_to(3400);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        hours   = 5'($urandom_range(0, 31));
        minutes = 6'($urandom_range(0, 63));
        seconds = 6'($urandom_range(0, 63));
      end
      step();
    end
    // One-cycle reset during bit 7 of a lane-0 digit frame.
    kk = pos / 70 + 2;
    run_to(70 * kk + 31);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    pos = 0;
    hours = 5'd7; minutes = 6'd5; seconds = 6'd33;
    run_to(1500);
    check(0, "frames_seen", (nchk[0] > 150) ? 1 : 0, 1);
    check(1, "frames_seen", (nchk[1] > 100) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
